// File: rtl/bau_result_sender.sv
`default_nettype none
// ============================================================================
//  Module   : bau_result_sender
//  Purpose  : Serialises one BAU result and its program counter into a
//             six-byte frame for a byte-wide UART transmitter:
//                 0xA5, result[15:8], result[7:0], pc[15:8], pc[7:0], xor
//             The result is sign-extended and the pc zero-extended to 16 bits.
//             The trailing byte is the XOR of the four payload bytes.
//  Ports    : clk      - single clock, rising edge
//             reset    - asynchronous, active-high reset
//             start    - frame request, sampled only while idle
//             result   - signed BAU result, MSB+1 bits
//             pc       - unsigned program counter, MSB+1 bits
//             tx_done  - one-cycle pulse from the transmitter, byte finished
//             tx_data  - byte presented to the transmitter
//             tx_start - registered one-cycle pulse launching tx_data
//             busy     - high from frame capture until frame completion
//             done     - registered one-cycle pulse at frame completion
//  Revision : 1.0 - initial release
// ============================================================================
module bau_result_sender #(
    parameter int MSB = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [MSB:0] result,
    input  logic [MSB:0] pc,
    input  logic         tx_done,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] c_header   = 8'hA5;
    localparam logic [2:0] c_last_idx = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t       r_state;
    logic [2:0]   r_idx;
    logic [MSB:0] r_result;
    logic [MSB:0] r_pc;

    logic [15:0]  w_result16;
    logic [15:0]  w_pc16;
    logic [7:0]   w_checksum;
    logic [2:0]   w_next_idx;
    logic [7:0]   w_next_byte;

    // ------------------------------------------------------------------------
    // Widen the captured operands to 16 bits. A zero-width replication is not
    // legal, so the full-width case is handled separately.
    // ------------------------------------------------------------------------
    generate
        if (MSB == 15) begin : g_full_width
            assign w_result16 = r_result;
            assign w_pc16     = r_pc;
        end else begin : g_extend
            assign w_result16 = {{(15 - MSB){r_result[MSB]}}, r_result};
            assign w_pc16     = {{(15 - MSB){1'b0}}, r_pc};
        end
    endgenerate

    // Checksum is built only from the captured copies so that input activity
    // during a frame cannot corrupt it.
    assign w_checksum = w_result16[15:8] ^ w_result16[7:0]
                      ^ w_pc16[15:8]     ^ w_pc16[7:0];

    assign w_next_idx = r_idx + 3'd1;

    // Byte that will be presented once the current one has been sent.
    always_comb begin
        w_next_byte = c_header;
        case (w_next_idx)
            3'd1:    w_next_byte = w_result16[15:8];
            3'd2:    w_next_byte = w_result16[7:0];
            3'd3:    w_next_byte = w_pc16[15:8];
            3'd4:    w_next_byte = w_pc16[7:0];
            3'd5:    w_next_byte = w_checksum;
            default: w_next_byte = c_header;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame sequencer. All outputs are registered here.
    //   IDLE   : capture operands on start, present header, pulse tx_start
    //   WAIT   : hold tx_data until the transmitter reports the byte finished
    //   SEND   : the cycle in which tx_start is high for bytes 1..5
    //   FINISH : single cycle with done=1, busy still high
    // tx_start and done are pulses, so they default low every cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= 3'd0;
            r_result <= '0;
            r_pc     <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_result <= result;
                        r_pc     <= pc;
                        r_idx    <= 3'd0;
                        busy     <= 1'b1;
                        tx_data  <= c_header;
                        tx_start <= 1'b1;
                        r_state  <= WAIT;
                    end
                end

                WAIT: begin
                    if (tx_done) begin
                        // ">=" keeps the index bounded even from a corrupted value
                        if (r_idx >= c_last_idx) begin
                            done    <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_idx    <= w_next_idx;
                            tx_data  <= w_next_byte;
                            tx_start <= 1'b1;
                            r_state  <= SEND;
                        end
                    end
                end

                SEND: begin
                    // tx_start is high during this cycle; tx_done is ignored
                    r_state <= WAIT;
                end

                FINISH: begin
                    // start is not sampled here; the next IDLE edge does it
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bau_result_sender.md
BAU_RESULT_SENDER -- requirements
Module: bau_result_sender

Interface
REQ-001 The block SHALL have parameter MSB, default 10, giving the MSB index of the result and pc inputs; the legal range is 7..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to send one frame; sampled only in IDLE.
REQ-005 The block SHALL have port result, input, MSB+1 bits: signed two's-complement BAU result.
REQ-006 The block SHALL have port pc, input, MSB+1 bits: unsigned program counter.
REQ-007 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse from the UART transmitter when a byte has finished.
REQ-008 The block SHALL have port tx_data, output, 8 bits: the byte presented to the UART transmitter.
REQ-009 The block SHALL have port tx_start, output, 1 bit: registered one-cycle pulse that launches tx_data.
REQ-010 The block SHALL have port busy, output, 1 bit: high from frame capture until frame completion.
REQ-011 The block SHALL have port done, output, 1 bit: registered one-cycle pulse when a frame completes.

Function
REQ-012 The frame SHALL be 6 bytes, sent in this order:
- 0xA5 header
- result sign-extended to 16 bits, high byte then low byte
- pc zero-extended to 16 bits, high byte then low byte
- checksum = XOR of the 4 payload bytes (the header is excluded)
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT, FINISH and SHALL power up in IDLE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL do all of the following at that edge:
- capture result and pc into internal registers
- clear the byte index to 0
- set busy=1
- present tx_data=0xA5
- pulse tx_start=1 for the following cycle
- move to WAIT
REQ-015 Later changes on result and pc SHALL have no effect on a frame already in flight.
REQ-016 In WAIT, the block SHALL hold tx_data stable and keep tx_start=0 until tx_done=1.
REQ-017 On a tx_done edge in WAIT with byte index < 5, the block SHALL:
- increment the index
- load the next byte onto tx_data
- move to SEND, which pulses tx_start for exactly one cycle and then returns to WAIT
REQ-018 The latency from tx_done to the next tx_start SHALL be exactly 1 cycle.
REQ-019 On a tx_done edge in WAIT with byte index = 5, the block SHALL move to FINISH.
REQ-020 FINISH SHALL last one cycle with done=1 and busy=1; the block SHALL return to IDLE with busy=0 on the next edge.
REQ-021 start SHALL be ignored while busy=1; no request is queued.
REQ-022 A start that is high in the cycle FINISH returns to IDLE SHALL be sampled at the next edge, so back-to-back frames are legal.
REQ-023 tx_done SHALL be ignored in IDLE, SEND and FINISH.
REQ-024 The checksum SHALL be computed from the captured registers, never from the live inputs.
REQ-025 The byte index SHALL be 3 bits and SHALL never exceed 5.

Reset
REQ-026 While reset=1, the block SHALL force the following values immediately, independent of clk:
- state=IDLE
- tx_start=0, busy=0, done=0
- tx_data=0x00
- byte index=0
- captured registers=0
REQ-027 A reset asserted mid-frame SHALL abort the frame; no further tx_start SHALL occur until a new start is sampled after reset release.
REQ-028 The first edge after reset release SHALL sample start normally.

Verification
REQ-029 Basic frame: MSB=10, result=11'h7FD (-3), pc=11'h012, start pulse, transmitter model answering tx_done 10 cycles after each tx_start -> tx_data sequence A5 FF FD 00 12 10; done pulses exactly once; busy falls the cycle after done.
REQ-030 Positive extremes: result=11'h3FF, pc=11'h7FF -> bytes A5 03 FF 07 FF 04.
REQ-031 Capture and ignore: result and pc change every cycle during the frame, and start is held high throughout -> bytes match the values at the capture edge; exactly 6 tx_start pulses per frame; a second frame begins the cycle after FINISH.
REQ-032 Spurious tx_done: tx_done pulses in IDLE and in the SEND cycle -> no state change, no extra tx_start, index unchanged.
REQ-033 Reset mid-operation: assert reset asynchronously during WAIT of byte 3 -> tx_start, busy and done go to 0 and tx_data to 0x00 immediately; no tx_start until the next start; a following frame is complete and correct.
REQ-034 Timing: tx_done held for 1 cycle in WAIT -> next tx_start occurs exactly 1 cycle later and lasts 1 cycle.
